display_bcd_scan: RTL and testbench

DISPLAY_BCD_SCAN -- requirements
Module: display_bcd_scan

---
 rtl/calc_display_pkg.sv | 23 ++
 rtl/bcd_to_7seg.sv | 31 +++
 rtl/display_bcd_scan.sv | 113 +++++++++++
 tb/tb_display_bcd_scan.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_display_pkg.sv
// rtl/calc_display_pkg.sv - segment patterns and scan FSM encoding shared by the display path
package calc_display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD nibble to active-low {g,f,e,d,c,b,a} decoder
module bcd_to_7seg
    import calc_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        if (i_blank) begin
            o_seg = SEG_BLANK;
        end else begin
            case (i_nibble)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/display_bcd_scan.sv
// rtl/display_bcd_scan.sv - latches BCD on DONE_IN rise and scans four 7-seg digits; LEADING_ZERO_BLANK_EN blanks leading zeros
module display_bcd_scan
    import calc_display_pkg::*;
#(
    parameter int PRESCALE = 50000
)
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] BCD_IN,
    input  logic        DONE_IN,
    output logic [6:0]  SEG,
    output logic [3:0]  AN,
    output logic        LATCHED
);

    localparam int             PW         = $clog2(PRESCALE);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);

    state_t         r_state;
    logic           r_done_q;
    logic [15:0]    r_disp;
    logic [PW-1:0]  r_presc;
    logic [1:0]     r_idx;
    logic           r_latched;
    logic [6:0]     r_seg;
    logic [3:0]     r_an;

    logic           w_edge;
    logic           w_tick;
    logic [3:0]     w_nibble;
    logic           w_blank;
    logic [6:0]     w_seg;

    assign w_edge  = DONE_IN & ~r_done_q;
    assign w_tick  = (r_presc == PRESC_LAST);
    assign SEG     = r_seg;
    assign AN      = r_an;
    assign LATCHED = r_latched;

    always_comb begin
        w_nibble = r_disp[3:0];
        case (r_idx)
            2'd0: w_nibble = r_disp[3:0];
            2'd1: w_nibble = r_disp[7:4];
            2'd2: w_nibble = r_disp[11:8];
            2'd3: w_nibble = r_disp[15:12];
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blanked when it and every digit above it are zero; units never blank.
    always_comb begin
        w_blank = 1'b0;
        case (r_idx)
            2'd1:    w_blank = (r_disp[15:4] == 12'h000);
            2'd2:    w_blank = (r_disp[15:8] == 8'h00);
            2'd3:    w_blank = (r_disp[15:12] == 4'h0);
            default: w_blank = 1'b0;
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    bcd_to_7seg u_dec (
        .i_nibble (w_nibble),
        .i_blank  (w_blank),
        .o_seg    (w_seg)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_done_q  <= 1'b0;
            r_disp    <= 16'h0000;
            r_presc   <= '0;
            r_idx     <= 2'd0;
            r_latched <= 1'b0;
            r_seg     <= SEG_BLANK;
            r_an      <= AN_OFF;
        end else begin
            r_done_q  <= DONE_IN;
            r_latched <= w_edge;
            if (w_edge) begin
                r_disp <= BCD_IN;
            end
            case (r_state)
                ST_IDLE: begin
                    r_an  <= AN_OFF;
                    r_seg <= SEG_BLANK;
                    if (w_edge) begin
                        r_state <= ST_SCAN;
                        r_presc <= '0;
                        r_idx   <= 2'd0;
                    end
                end
                ST_SCAN: begin
                    // Outputs follow the index one cycle later; captures never disturb the scan timing.
                    r_an  <= ~(4'b0001 << r_idx);
                    r_seg <= w_seg;
                    if (w_tick) begin
                        r_presc <= '0;
                        r_idx   <= r_idx + 2'd1;
                    end else begin
                        r_presc <= r_presc + PW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_bcd_scan.sv
// tb/tb_display_bcd_scan.sv - scoreboard bench for display_bcd_scan at PRESCALE=4
module tb_display_bcd_scan;

    localparam int P = 4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        DONE_IN;
    logic [15:0] BCD_IN;
    logic [6:0]  SEG;
    logic [3:0]  AN;
    logic        LATCHED;

    int          checks = 0;
    int          errors = 0;
    int          lat_count = 0;
    logic [11:0] sb_q[$];

    display_bcd_scan #(.PRESCALE(P)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .BCD_IN  (BCD_IN),
        .DONE_IN (DONE_IN),
        .SEG     (SEG),
        .AN      (AN),
        .LATCHED (LATCHED)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic blank_of(input logic [15:0] v, input int idx);
`ifdef LEADING_ZERO_BLANK_EN
        return (idx > 0) && ((v >> (4 * idx)) == 16'h0);
`else
        return 1'b0;
`endif
    endfunction

    // Sample k counts clocks after the capturing edge; digit i is visible on samples i*P+1 .. i*P+P.
    function automatic logic [11:0] exp_at(input logic [15:0] v, input int k, input logic lat);
        int         idx;
        logic [3:0] an;
        logic [6:0] sg;
        idx = ((k - 1) / P) % 4;
        an  = ~(4'b0001 << idx);
        sg  = blank_of(v, idx) ? 7'b1111111 : seg_of(v[4*idx +: 4]);
        return {lat, an, sg};
    endfunction

    task automatic push_idle(input int n, input logic lat);
        for (int i = 0; i < n; i++) sb_q.push_back({lat, 4'b1111, 7'b1111111});
    endtask

    task automatic push_scan(input logic [15:0] v, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) sb_q.push_back(exp_at(v, k, 1'b0));
    endtask

    task automatic run_cycles(input string ph, input int n);
        logic [11:0] e;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (LATCHED) lat_count++;
            if (sb_q.size() == 0) begin
                chk({ph, "_sb_empty"}, 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk({ph, "_latched"}, LATCHED, e[11]);
                chk({ph, "_an"}, AN, e[10:7]);
                chk({ph, "_seg"}, SEG, e[6:0]);
            end
        end
    endtask

    task automatic do_reset(input logic done);
        @(negedge CLK);
        DONE_IN = done;
        RST_N   = 1'b0;
        #2;
        chk("rst_an", AN, 4'b1111);
        chk("rst_seg", SEG, 7'b1111111);
        chk("rst_latched", LATCHED, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
        lat_count = 0;
    endtask

    task automatic scan_phase(input string ph, input logic [15:0] v, input int n);
        do_reset(1'b0);
        BCD_IN  = v;
        DONE_IN = 1'b1;
        push_idle(1, 1'b1);
        push_scan(v, 1, n);
        run_cycles(ph, 1);
        DONE_IN = 1'b0;
        run_cycles(ph, n);
        chk({ph, "_latch_cnt"}, lat_count, 1);
    endtask

    initial begin
        RST_N   = 1'b0;
        DONE_IN = 1'b0;
        BCD_IN  = 16'h0000;

        do_reset(1'b0);
        push_idle(100, 1'b0);
        run_cycles("idle", 100);
        chk("idle_latch_cnt", lat_count, 0);

        do_reset(1'b0);
        BCD_IN  = 16'h1987;
        DONE_IN = 1'b1;
        push_idle(1, 1'b1);
        push_scan(16'h1987, 1, 40);
        run_cycles("s1987", 31);
        DONE_IN = 1'b0;
        run_cycles("s1987", 10);
        chk("s1987_latch_cnt", lat_count, 1);

        scan_phase("s0007", 16'h0007, 16);
        scan_phase("s00a0", 16'h00A0, 16);

        // Second capture lands on the tick at sample 8; sample 8 still shows the old value.
        do_reset(1'b0);
        BCD_IN  = 16'h1111;
        DONE_IN = 1'b1;
        push_idle(1, 1'b1);
        push_scan(16'h1111, 1, 7);
        run_cycles("tick_cap", 2);
        DONE_IN = 1'b0;
        run_cycles("tick_cap", 6);
        BCD_IN  = 16'h2222;
        DONE_IN = 1'b1;
        sb_q.push_back(exp_at(16'h1111, 8, 1'b1));
        push_scan(16'h2222, 9, 24);
        run_cycles("tick_cap", 1);
        DONE_IN = 1'b0;
        run_cycles("tick_cap", 16);
        chk("tick_cap_latch_cnt", lat_count, 2);

        // Asynchronous reset between edges, then idle until a fresh DONE_IN edge.
        do_reset(1'b0);
        BCD_IN  = 16'h1987;
        DONE_IN = 1'b1;
        push_idle(1, 1'b1);
        push_scan(16'h1987, 1, 9);
        run_cycles("pre_arst", 1);
        DONE_IN = 1'b0;
        run_cycles("pre_arst", 9);
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_an", AN, 4'b1111);
        chk("arst_seg", SEG, 7'b1111111);
        chk("arst_latched", LATCHED, 1'b0);
        @(negedge CLK);
        #2;
        RST_N = 1'b1;
        push_idle(12, 1'b0);
        run_cycles("post_arst", 12);
        BCD_IN  = 16'h4321;
        DONE_IN = 1'b1;
        push_idle(1, 1'b1);
        push_scan(16'h4321, 1, 8);
        run_cycles("s4321", 1);
        DONE_IN = 1'b0;
        run_cycles("s4321", 8);

        // DONE_IN already high across reset release counts as an edge on the first clock.
        BCD_IN = 16'h0560;
        do_reset(1'b1);
        push_idle(1, 1'b1);
        push_scan(16'h0560, 1, 16);
        run_cycles("rel_high", 1);
        DONE_IN = 1'b0;
        run_cycles("rel_high", 16);
        chk("rel_high_latch_cnt", lat_count, 1);
        chk("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
